// File: rtl/cpu_boot_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// boot_ctrl_defs: shared definitions for the CPU boot/run controller.
//   - boot_state_e : controller state encoding (IDLE=0 .. DONE=4)
//   - ch_w()       : width of a channel index for a given channel count
//   - `BOOT_LD_LEN_SLICE(vec, idx, w) : selects channel idx's length field
//     out of the packed per-channel length vector.
// ---------------------------------------------------------------------------
`ifndef BOOT_CTRL_DEFS_SV
`define BOOT_CTRL_DEFS_SV

`define BOOT_LD_LEN_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package boot_ctrl_defs;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CPU_RST = 3'd2,
    RUN     = 3'd3,
    DONE    = 3'd4
  } boot_state_e;

  // A single channel still needs a 1-bit index so the port stays legal.
  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

`endif

// File: rtl/cpu_boot_ctrl_watchdog.sv
// ---------------------------------------------------------------------------
// boot_run_watchdog: saturating RUN-cycle counter with budget compare.
//   clk, reset   : clock, synchronous active-high reset
//   clr          : clears the counter (new boot sequence)
//   en           : count this cycle (controller is in RUN)
//   run_cycles   : budget; 0 means unlimited
//   cycle_cnt    : cycles counted so far, saturates at all-ones
//   expire       : this enabled cycle is the last one of the budget
// ---------------------------------------------------------------------------
module boot_run_watchdog #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] run_cycles,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_reg <= '0;
    end else if (en && !(&cnt_reg)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Once saturated, cnt+1 wraps to 0 and can never equal a nonzero budget.
  assign expire    = en && (|run_cycles) && ((cnt_reg + CNT_W'(1)) == run_cycles);
  assign cycle_cnt = cnt_reg;

endmodule

// File: rtl/cpu_boot_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_boot_ctrl: boot and run controller for the MIPS CPU.
// Copies NUM_CH memory images from a boot source into the CPU memories,
// holds the CPU in reset for RST_CYCLES cycles, then runs it until it halts
// or the cycle budget expires.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               pulse to begin load/reset/run (ignored while busy)
//   run_cycles          RUN budget, 0 = unlimited (sampled at start)
//   ld_len              per-channel word counts, slice i = channel i
//   src_req/ch/addr     boot-source read request, held until src_valid
//   src_rdata/src_valid boot-source response
//   mem_we/addr/wdata   one-hot write port to the target memories
//   cpu_resetn          CPU reset, active-low
//   cpu_halt            CPU halted
//   busy/done/timeout   sequence status (done sticky until next start)
//   cycle_cnt           cycles spent in RUN
//   chksum              sum of all loaded words
//
// Build option: define BOOT_CHKSUM_EN to build the load checksum; without it
// chksum reads 0 and no adder exists.
// ---------------------------------------------------------------------------
module cpu_boot_ctrl
  import boot_ctrl_defs::*;
#(
  parameter int NUM_CH     = 3,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CNT_W-1:0]         run_cycles,
  input  logic [NUM_CH*ADDR_W-1:0] ld_len,
  output logic                     src_req,
  output logic [ch_w(NUM_CH)-1:0]  src_ch,
  output logic [ADDR_W-1:0]        src_addr,
  input  logic [DATA_W-1:0]        src_rdata,
  input  logic                     src_valid,
  output logic [NUM_CH-1:0]        mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     cpu_resetn,
  input  logic                     cpu_halt,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [DATA_W-1:0]        chksum
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  boot_state_e state_reg, state_next;

  logic [NUM_CH*ADDR_W-1:0] len_reg;
  logic [CH_W-1:0]          ch_reg;
  logic [ADDR_W-1:0]        addr_reg;
  logic                     req_reg;
  logic                     last_reg;      // the word just captured was the final one
  logic [NUM_CH-1:0]        mem_we_reg;
  logic [ADDR_W-1:0]        mem_addr_reg;
  logic [DATA_W-1:0]        mem_wdata_reg;
  logic [RST_W-1:0]         rst_cnt_reg;
  logic                     done_reg;
  logic                     timeout_reg;
  logic [CNT_W-1:0]         budget_reg;

  logic [NUM_CH-1:0] ld_nz, len_nz;
  logic [CH_W-1:0]   first_ch, next_ch;
  logic              first_found, next_found;
  logic [ADDR_W-1:0] cur_len;
  logic              more_words;
  logic              start_acc, load_acc, wr_cycle, rst_last;
  logic              wd_expire;

  // Per-channel "has something to load" flags, for the start request and
  // for the latched lengths used while walking the channels.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_len_nz
      assign ld_nz[gi]  = |`BOOT_LD_LEN_SLICE(ld_len, gi, ADDR_W);
      assign len_nz[gi] = |`BOOT_LD_LEN_SLICE(len_reg, gi, ADDR_W);
    end
  endgenerate

  // Descending scan so the lowest qualifying channel is the one kept.
  always_comb begin
    first_ch    = '0;
    first_found = 1'b0;
    next_ch     = '0;
    next_found  = 1'b0;
    cur_len     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ld_nz[i]) begin
        first_found = 1'b1;
        first_ch    = CH_W'(i);
      end
      if (len_nz[i] && (CH_W'(i) > ch_reg)) begin
        next_found = 1'b1;
        next_ch    = CH_W'(i);
      end
      if (ch_reg == CH_W'(i)) begin
        cur_len = `BOOT_LD_LEN_SLICE(len_reg, i, ADDR_W);
      end
    end
  end

  // addr never exceeds len-1, so addr+1 cannot wrap.
  assign more_words = (addr_reg + ADDR_W'(1)) < cur_len;

  boot_run_watchdog #(
    .CNT_W(CNT_W)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clr       (start_acc),
    .en        (state_reg == RUN),
    .run_cycles(budget_reg),
    .cycle_cnt (cycle_cnt),
    .expire    (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    start_acc  = 1'b0;
    load_acc   = 1'b0;
    wr_cycle   = 1'b0;
    cpu_resetn = 1'b0;
    busy       = 1'b1;
    rst_last   = (rst_cnt_reg == RST_W'(RST_CYCLES - 1));
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_acc  = 1'b1;
          state_next = first_found ? LOAD : CPU_RST;
        end
      end
      LOAD: begin
        load_acc = req_reg && src_valid;
        wr_cycle = |mem_we_reg;
        if (wr_cycle && last_reg) begin
          state_next = CPU_RST;
        end
      end
      CPU_RST: begin
        if (rst_last) begin
          state_next = RUN;
        end
      end
      RUN: begin
        cpu_resetn = 1'b1;
        if (cpu_halt || wd_expire) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b0;
        cpu_resetn = 1'b1;
        if (start) begin
          start_acc  = 1'b1;
          state_next = first_found ? LOAD : CPU_RST;
        end
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Load handshake: the request drops on the accept edge, the write strobe
  // fires the following cycle, and the next request rises on the write edge,
  // giving at most one word every two cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_reg       <= '0;
      ch_reg        <= '0;
      addr_reg      <= '0;
      req_reg       <= 1'b0;
      last_reg      <= 1'b0;
      mem_we_reg    <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rst_cnt_reg   <= '0;
      done_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
      budget_reg    <= '0;
    end else begin
      mem_we_reg <= '0;
      if (start_acc) begin
        budget_reg  <= run_cycles;
        len_reg     <= ld_len;
        ch_reg      <= first_ch;
        addr_reg    <= '0;
        last_reg    <= 1'b0;
        req_reg     <= first_found;
        rst_cnt_reg <= '0;
        done_reg    <= 1'b0;
        timeout_reg <= 1'b0;
      end
      if (load_acc) begin
        req_reg       <= 1'b0;
        mem_we_reg    <= NUM_CH'(1) << ch_reg;
        mem_addr_reg  <= addr_reg;
        mem_wdata_reg <= src_rdata;
        if (more_words) begin
          addr_reg <= addr_reg + 1'b1;
        end else if (next_found) begin
          ch_reg   <= next_ch;
          addr_reg <= '0;
        end else begin
          last_reg <= 1'b1;
        end
      end
      if (wr_cycle && !last_reg) begin
        req_reg <= 1'b1;
      end
      if (state_reg == CPU_RST) begin
        rst_cnt_reg <= rst_cnt_reg + 1'b1;
      end
      // Halt has priority over budget expiry.
      if (state_reg == RUN && state_next == DONE) begin
        done_reg    <= 1'b1;
        timeout_reg <= !cpu_halt;
      end
    end
  end

`ifdef BOOT_CHKSUM_EN
  logic [DATA_W-1:0] chksum_reg;

  // Accumulated on the accept edge so the sum moves with mem_we.
  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      chksum_reg <= '0;
    end else if (load_acc) begin
      chksum_reg <= chksum_reg + src_rdata;
    end
  end

  assign chksum = chksum_reg;
`else
  assign chksum = '0;
`endif

  assign src_req   = req_reg;
  assign src_ch    = ch_reg;
  assign src_addr  = addr_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign done      = done_reg;
  assign timeout   = timeout_reg;

endmodule

// File: doc/cpu_boot_ctrl.md
Name: cpu_boot_ctrl

Overview:
Synthesizable boot and run controller for the MIPS CPU. It replaces the bench-side memory preload, reset pulse and fixed run window with hardware.
- Copies NUM_CH memory images (imem, dmem, regfile) from a boot source into the CPU memories.
- Pulses the CPU reset for a configurable number of cycles.
- Runs the CPU for a programmable cycle budget or until it halts, then reports done or timeout.

Parameters:
NUM_CH, 3, number of target memories (channel 0 = imem, 1 = dmem, 2 = regfile)
ADDR_W, 8, word address width per channel
DATA_W, 32, word width
RST_CYCLES, 2, CPU reset-low duration in cycles (>=1)
CNT_W, 32, run cycle counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse: begin load/reset/run sequence
run_cycles  in  CNT_W  run budget; 0 = unlimited (until cpu_halt)
ld_len  in  NUM_CH*ADDR_W  words to load per channel; slice i = channel i; 0 = skip channel
src_req  out  1  boot-source read request
src_ch  out  $clog2(NUM_CH)  channel of request
src_addr  out  ADDR_W  word address of request
src_rdata  in  DATA_W  read data, valid with src_valid
src_valid  in  1  read response; completes current src_req
mem_we  out  NUM_CH  one-hot write strobe to target memory
mem_addr  out  ADDR_W  write address
mem_wdata  out  DATA_W  write data
cpu_resetn  out  1  CPU reset, active-low
cpu_halt  in  1  CPU halt indication
busy  out  1  sequence in progress
done  out  1  sequence finished (sticky)
timeout  out  1  finished by budget expiry, not halt
cycle_cnt  out  CNT_W  cycles spent in RUN
chksum  out  DATA_W  load checksum (see Optional Feature)

Behaviour:
- Reset values: src_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_resetn=0, busy=0, done=0, timeout=0, cycle_cnt=0, chksum=0, state=IDLE.
- States: IDLE, LOAD, CPU_RST, RUN, DONE. CPU is held in reset in IDLE, LOAD and CPU_RST.
- IDLE / DONE, start=1: clear done, timeout, cycle_cnt and chksum; ch=first channel with nonzero length; addr=0; busy=1; go to LOAD. If all lengths are 0, go directly to CPU_RST.
- start while busy: ignored.
- LOAD:
  - src_req=1 with src_ch/src_addr, held stable until src_valid.
  - Data accepted on the cycle src_valid=1. On the next cycle mem_we[ch]=1 for exactly one cycle, with mem_addr=addr and mem_wdata=captured data.
  - src_valid in the same cycle as src_req rise is legal: max throughput is 1 word per 2 cycles.
  - src_valid while src_req=0: ignored.
  - After the last word of a channel, advance to the next channel with nonzero length. After the final channel's write, go to CPU_RST.
  - ld_len is sampled at start only. Words are loaded in address order 0..len-1, no wrap.
- CPU_RST: cpu_resetn=0 for exactly RST_CYCLES cycles, then RUN.
- RUN:
  - cpu_resetn=1. cycle_cnt increments each cycle and saturates at all-ones.
  - Exit on cpu_halt=1: go to DONE, timeout=0.
  - Exit when run_cycles!=0 and cycle_cnt+1==run_cycles: go to DONE, timeout=1.
  - Halt and expiry in the same cycle: halt wins, timeout=0.
  - run_cycles is sampled at start.
- DONE: busy=0, done=1, cpu_resetn=1 (CPU is left running/halted for inspection), cycle_cnt held.
- reset asserted in any state: all outputs return to reset values on the next edge. Any in-flight src_req is abandoned and a late src_valid is ignored.

Optional Feature:
BOOT_CHKSUM_EN:
- Defined: chksum = running sum mod 2^DATA_W of every word written via mem_wdata, across all channels. It updates in the same cycle as mem_we and is cleared on start.
- Undefined: chksum is tied to 0 and no adder is built. The port is kept so the interface is unchanged.

Decomposition:
- Shared package/include boot_ctrl_defs: state encodings (IDLE=0, LOAD=1, CPU_RST=2, RUN=3, DONE=4), CH_W=$clog2(NUM_CH) helper, ld_len slice macro.
- One natural sub-module, boot_run_watchdog: the saturating cycle counter plus budget compare. Inputs clk, reset, clr, en, run_cycles. Outputs cycle_cnt, expire.

Test Plan:
- ld_len={3,2,4} (ch2,ch1,ch0), src returns data=0x1000+addr with 0-cycle response -> 9 mem_we pulses in order ch0 a0..3, ch1 a0..1, ch2 a0..2; then cpu_resetn low 2 cycles.
- run_cycles=100, cpu_halt=0 -> done=1, timeout=1, cycle_cnt=100, busy=0.
- run_cycles=100, cpu_halt pulsed at RUN cycle 40 -> done=1, timeout=0, cycle_cnt=40. Halt on cycle 100 -> timeout=0.
- ld_len={0,0,0}, start -> no src_req; CPU_RST entered next cycle; start pulsed during RUN is ignored.
- src_valid delayed 5 cycles per word, reset pulsed mid-LOAD at word 2 -> src_req and mem_we drop to 0, cpu_resetn=0, state IDLE; a stale src_valid causes no write.
- BOOT_CHKSUM_EN defined, words 0xFFFFFFFF and 0x00000002 -> chksum=0x00000001. Undefined -> chksum=0.
